mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 0, meaning extra memory access cycles per transaction (legal range 0..15).
REQ-002 SHALL provide port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 SHALL provide port i_req, input, 1, instruction-fetch read request.
REQ-005 SHALL provide port i_addr, input, 32, instruction byte address.
REQ-006 SHALL provide port i_ack, output, 1, one-cycle completion pulse for instruction port.
REQ-007 SHALL provide port i_rdata, output, 32, fetched word, held until next instruction-port completion.
REQ-008 SHALL provide port d_req, input, 1, data-port request.
REQ-009 SHALL provide port d_we, input, 1, data-port write enable (1 = write, 0 = read).
REQ-010 SHALL provide port d_addr, input, 32, data byte address.
REQ-011 SHALL provide port d_wdata, input, 32, data write word.
REQ-012 SHALL provide port d_ack, output, 1, one-cycle completion pulse for data port.
REQ-013 SHALL provide port d_rdata, output, 32, read word, held until next data-port read completion.
REQ-014 SHALL provide ports mem_address (output, 32), mem_writeData (output, 32), mem_memRead (output, 1), mem_memWrite (output, 1), driving the shared unified memory.
REQ-015 SHALL provide port mem_memData, input, 32, memory read data (combinational from mem_address when mem_memRead=1).
REQ-016 SHALL provide port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCESS, RESP; all outputs registered.
REQ-018 SHALL, in IDLE with any request high, latch the winner's address, write data, write enable and owner id, and move to ACCESS next cycle.
REQ-019 SHALL, in ACCESS, drive mem_address/mem_writeData from latched values and assert mem_memRead (read) or mem_memWrite (write) for exactly WAIT_CYCLES+1 cycles, counted by a down-counter loaded with WAIT_CYCLES.
REQ-020 SHALL capture mem_memData into the owner's rdata register at the last ACCESS cycle of a read; writes leave both rdata registers unchanged.
REQ-021 SHALL, in RESP, assert the owner's ack for exactly one cycle, then return to IDLE; no arbitration occurs in RESP.
REQ-022 SHALL yield latency: request sampled in IDLE at cycle N, ack high in cycle N+2+WAIT_CYCLES.
REQ-023 SHALL arbitrate round-robin: on simultaneous requests grant the port not granted last; single requester always wins; last-grant register updates on every grant.
REQ-024 SHALL treat instruction port as read-only (never asserts mem_memWrite for it).
REQ-025 SHALL ignore requester inputs after latching; deassertion of req mid-transaction does not abort it.
REQ-026 SHALL treat req high in IDLE as a new request; requesters drop req after seeing ack.
REQ-027 SHALL pass 32-bit byte addresses unmodified, no alignment checks (memory supports unaligned word access).
REQ-028 SHALL hold mem_memRead=0 and mem_memWrite=0 in IDLE and RESP; mem_address/mem_writeData hold last latched values.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, force state IDLE, all acks 0, mem_memRead 0, mem_memWrite 0, busy 0, mem_address 0, mem_writeData 0, i_rdata 0, d_rdata 0, counter 0, last-grant = data port (so first tie grants instruction port).
REQ-030 SHALL abort any in-flight transaction on reset with no ack issued.

Structure
REQ-031 SHALL place state encoding, port-id constants (PORT_I=0, PORT_D=1) and WAIT_CYCLES range limit in shared package mem_arb_pkg.
REQ-032 SHALL use one sub-module rr_arbiter2: two-requester round-robin picker (inputs req[1:0], last_grant; output grant id, valid).

Verification
REQ-033 Data write then read: d_we=1, d_addr=3, d_wdata=200 -> mem_memWrite=1 with address 3 data 200 at N+1, d_ack at N+2; read addr 3 -> d_rdata=200.
REQ-034 Instruction fetch: memory word at 20 = 0x000B72DD, i_req, i_addr=20 -> i_rdata=0x000B72DD, i_ack at N+2, d_ack stays 0.
REQ-035 Contention after reset: i_req and d_req high same cycle, both held until ack -> i_ack first, d_ack 3 cycles later; repeat -> order alternates per last-grant.
REQ-036 WAIT_CYCLES=3: data read -> mem_memRead high exactly 4 cycles, d_ack at N+5.
REQ-037 Reset=0 during ACCESS of write -> no ack, mem_memWrite=0 and busy=0 after that edge, all outputs at reset values.
REQ-038 Unaligned: write 0xFFFFFFFE at 30, read at 30 -> d_rdata=0xFFFFFFFE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port unified-memory arbiter:
// FSM encoding, port identifiers, wait-state limits and the latched
// transaction record.
package mem_arb_pkg;

  // Largest supported number of extra memory cycles per transaction
  localparam int WAIT_MAX = 15;

  // Width of the wait-state down-counter (must hold WAIT_MAX)
  localparam int CNT_W = 4;

  // Number of requesting ports (instruction + data)
  localparam int NUM_PORTS = 2;

  // Port identifier; also used as the index into per-port arrays
  typedef logic port_id_t;

  localparam port_id_t PORT_I = 1'b0;
  localparam port_id_t PORT_D = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Everything captured from the winning requester at grant time
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    port_id_t    owner;
  } txn_t;

  // Convert the elaboration-time wait parameter into a counter load
  // value, clamping anything outside 0..WAIT_MAX into range.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    if (cycles < 0) begin
      return '0;
    end else if (cycles > WAIT_MAX) begin
      return CNT_W'(WAIT_MAX);
    end else begin
      return CNT_W'(cycles);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. Purely combinational: the caller
// owns the last-grant register and decides when a grant is taken.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,        // bit PORT_I = instruction, bit PORT_D = data
  input  port_id_t   last_grant_i, // port that won the previous grant
  output port_id_t   grant_o,      // winning port id (valid only with valid_o)
  output logic       valid_o       // at least one request present
);

  // On a tie the port that did not win last time gets the grant;
  // a lone requester always wins.
  always_comb begin
    valid_o = |req_i;
    grant_o = PORT_I;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      grant_o = ~last_grant_i;
    end else if (req_i[PORT_D]) begin
      grant_o = PORT_D;
    end else begin
      grant_o = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between an instruction-fetch
// port (read-only) and a data port (read/write). One transaction is
// in flight at a time: IDLE grants, ACCESS drives the memory for
// WAIT_CYCLES+1 cycles, RESP pulses the owner's ack for one cycle.
// Every output comes straight from a register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,          // synchronous, active low

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,

  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData,

  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_id_t          last_grant_q, last_grant_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;

  logic              ack_q   [NUM_PORTS];
  logic [31:0]       rdata_q [NUM_PORTS];

  port_id_t          grant;
  logic              grant_valid;
  logic              access_last;

  // Request vector indexed by port id for the picker
  logic [1:0]        req_vec;
  assign req_vec[PORT_I] = i_req;
  assign req_vec[PORT_D] = d_req;

  rr_arbiter2 u_rr (
    .req_i        (req_vec),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .valid_o      (grant_valid)
  );

  // Final memory cycle of the current transaction
  assign access_last = (state_q == ST_ACCESS) && (cnt_q == '0);

  // State register; reset abandons whatever was in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitration only ever happens in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values, registered below so outputs are glitch-free
  always_comb begin
    txn_d        = txn_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    busy_d       = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          txn_d.owner  = grant;
          last_grant_d = grant;
          cnt_d        = WAIT_LOAD;
          if (grant == PORT_D) begin
            txn_d.addr  = d_addr;
            txn_d.wdata = d_wdata;
            txn_d.we    = d_we;
          end else begin
            // Instruction side is read-only; keep the old write data
            txn_d.addr  = i_addr;
            txn_d.we    = 1'b0;
          end
          mem_rd_d = ~txn_d.we;
          mem_wr_d = txn_d.we;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - 1'b1;
          mem_rd_d = ~txn_q.we;
          mem_wr_d = txn_q.we;
        end
      end
      default: begin
      end
    endcase
  end

  // Shared datapath and strobe registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      txn_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_D;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      txn_q        <= txn_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
    end
  end

  // Per-port completion: ack pulse and read-data capture for the owner
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic hit;
    assign hit = access_last && (txn_q.owner == port_id_t'(gi));

    // Ack follows the last access cycle; read data is sampled on that same edge
    always_ff @(posedge clk) begin
      if (!reset) begin
        ack_q[gi]   <= 1'b0;
        rdata_q[gi] <= '0;
      end else begin
        ack_q[gi] <= hit;
        if (hit && !txn_q.we) begin
          rdata_q[gi] <= mem_memData;
        end
      end
    end
  end

  assign i_ack         = ack_q[PORT_I];
  assign d_ack         = ack_q[PORT_D];
  assign i_rdata       = rdata_q[PORT_I];
  assign d_rdata       = rdata_q[PORT_D];
  assign mem_address   = txn_q.addr;
  assign mem_writeData = txn_q.wdata;
  assign mem_memRead   = mem_rd_q;
  assign mem_memWrite  = mem_wr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with no wait states and
// one with WAIT_CYCLES=3, each wired to its own small word memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  always #5 clk = ~clk;

  // ---------------- instance with WAIT_CYCLES = 0 ----------------
  logic        i_req0, d_req0, d_we0;
  logic [31:0] i_addr0, d_addr0, d_wdata0;
  logic        i_ack0, d_ack0, busy0, mem_memRead0, mem_memWrite0;
  logic [31:0] i_rdata0, d_rdata0, mem_address0, mem_writeData0, mem_memData0;

  mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req0), .i_addr(i_addr0), .i_ack(i_ack0), .i_rdata(i_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ack(d_ack0), .d_rdata(d_rdata0),
    .mem_address(mem_address0), .mem_writeData(mem_writeData0),
    .mem_memRead(mem_memRead0), .mem_memWrite(mem_memWrite0),
    .mem_memData(mem_memData0), .busy(busy0)
  );

  // ---------------- instance with WAIT_CYCLES = 3 ----------------
  logic        i_req3, d_req3, d_we3;
  logic [31:0] i_addr3, d_addr3, d_wdata3;
  logic        i_ack3, d_ack3, busy3, mem_memRead3, mem_memWrite3;
  logic [31:0] i_rdata3, d_rdata3, mem_address3, mem_writeData3, mem_memData3;

  mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_address(mem_address3), .mem_writeData(mem_writeData3),
    .mem_memRead(mem_memRead3), .mem_memWrite(mem_memWrite3),
    .mem_memData(mem_memData3), .busy(busy3)
  );

  // ---------------- memory models (64 words, exact-address) ----------------
  logic [31:0] mem0 [0:63];
  logic [31:0] mem3 [0:63];

  always @(posedge clk) begin
    if (preload) begin
      mem0[20] <= 32'h000B72DD;
    end else begin
      if (mem_memWrite0) mem0[mem_address0[5:0]] <= mem_writeData0;
      if (mem_memWrite3) mem3[mem_address3[5:0]] <= mem_writeData3;
    end
  end

  assign mem_memData0 = mem_memRead0 ? mem0[mem_address0[5:0]] : 32'hDEADBEEF;
  assign mem_memData3 = mem_memRead3 ? mem3[mem_address3[5:0]] : 32'hDEADBEEF;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One uncontended transaction on dut0, checked cycle by cycle
  task automatic txn0(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input string tag);
    if (is_d) begin
      d_req0 = 1'b1; d_we0 = we; d_addr0 = addr; d_wdata0 = wdata;
    end else begin
      i_req0 = 1'b1; i_addr0 = addr;
    end
    @(negedge clk);
    check({tag, "_memRead"},  {31'd0, mem_memRead0},  {31'd0, ~we});
    check({tag, "_memWrite"}, {31'd0, mem_memWrite0}, {31'd0, we});
    check({tag, "_addr"}, mem_address0, addr);
    if (we) check({tag, "_wdata"}, mem_writeData0, wdata);
    check({tag, "_ack_early"}, {30'd0, i_ack0, d_ack0}, 32'd0);
    @(negedge clk);
    check({tag, "_ack"}, {30'd0, i_ack0, d_ack0}, is_d ? 32'd1 : 32'd2);
    check({tag, "_strobes_off"}, {30'd0, mem_memRead0, mem_memWrite0}, 32'd0);
    if (!we) check({tag, "_rdata"}, is_d ? d_rdata0 : i_rdata0, exp_rd);
    i_req0 = 1'b0; d_req0 = 1'b0; d_we0 = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {29'd0, busy0, i_ack0, d_ack0}, 32'd0);
  endtask

  // Both ports request in the same cycle; each drops its req on its ack
  task automatic tie0(input int exp_i, input int exp_d, input string tag);
    int ic = -1;
    int dc = -1;
    i_req0 = 1'b1; i_addr0 = 32'd20;
    d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 32'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (i_ack0 && ic < 0) begin ic = c; i_req0 = 1'b0; end
      if (d_ack0 && dc < 0) begin dc = c; d_req0 = 1'b0; end
    end
    i_req0 = 1'b0; d_req0 = 1'b0;
    check({tag, "_i_ack_cycle"}, ic, exp_i);
    check({tag, "_d_ack_cycle"}, dc, exp_d);
  endtask

  // Data transaction on dut3: strobe must last 4 cycles, ack in cycle 5
  task automatic wait3(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input string tag);
    int hi = 0;
    int bad = 0;
    int first = -1;
    int ac = -1;
    d_req3 = 1'b1; d_we3 = we; d_addr3 = addr; d_wdata3 = wdata;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (we ? mem_memWrite3 : mem_memRead3) begin
        hi++;
        if (first < 0) first = c;
      end
      if (we ? mem_memRead3 : mem_memWrite3) bad++;
      if (d_ack3 && ac < 0) begin ac = c; d_req3 = 1'b0; end
    end
    d_req3 = 1'b0; d_we3 = 1'b0;
    check({tag, "_strobe_cycles"}, hi, 32'd4);
    check({tag, "_strobe_first"}, first, 32'd1);
    check({tag, "_wrong_strobe"}, bad, 32'd0);
    check({tag, "_ack_cycle"}, ac, 32'd5);
    if (!we) check({tag, "_rdata"}, d_rdata3, exp_rd);
  endtask

  initial begin
    reset = 1'b0; preload = 1'b1;
    i_req0 = 0; d_req0 = 0; d_we0 = 0; i_addr0 = 0; d_addr0 = 0; d_wdata0 = 0;
    i_req3 = 0; d_req3 = 0; d_we3 = 0; i_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    // Reset values
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_acks", {30'd0, i_ack0, d_ack0}, 32'd0);
    check("rst_strobes", {30'd0, mem_memRead0, mem_memWrite0}, 32'd0);
    check("rst_addr", mem_address0, 32'd0);
    check("rst_wdata", mem_writeData0, 32'd0);
    check("rst_i_rdata", i_rdata0, 32'd0);
    check("rst_d_rdata", d_rdata0, 32'd0);
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Data write then read back
    txn0(1'b1, 1'b1, 32'd3, 32'd200, 32'd0, "wr3");
    check("mem_word3", mem0[3], 32'd200);
    check("addr_hold_idle", mem_address0, 32'd3);
    txn0(1'b1, 1'b0, 32'd3, 32'd0, 32'd200, "rd3");

    // Instruction fetch
    txn0(1'b0, 1'b0, 32'd20, 32'd0, 32'h000B72DD, "if20");
    check("d_rdata_hold", d_rdata0, 32'd200);

    // Unaligned address passes through untouched
    txn0(1'b1, 1'b1, 32'd30, 32'hFFFFFFFE, 32'd0, "wr30");
    txn0(1'b1, 1'b0, 32'd30, 32'd0, 32'hFFFFFFFE, "rd30");
    check("i_rdata_hold", i_rdata0, 32'h000B72DD);

    // Reset in the middle of a write
    d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 32'd40; d_wdata0 = 32'h00001234;
    @(negedge clk);
    check("abort_wr_active", {31'd0, mem_memWrite0}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    d_req0 = 1'b0; d_we0 = 1'b0;
    check("abort_memWrite", {31'd0, mem_memWrite0}, 32'd0);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_acks", {30'd0, i_ack0, d_ack0}, 32'd0);
    check("abort_addr", mem_address0, 32'd0);
    check("abort_wdata", mem_writeData0, 32'd0);
    check("abort_rdata", d_rdata0 | i_rdata0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_ack", {29'd0, busy0, i_ack0, d_ack0}, 32'd0);

    // Contention after reset: instruction wins first, data 3 cycles later
    tie0(2, 5, "tie1");
    check("tie1_i_rdata", i_rdata0, 32'h000B72DD);
    check("tie1_d_rdata", d_rdata0, 32'd200);
    // Instruction alone wins, so the next tie goes to data
    txn0(1'b0, 1'b0, 32'd20, 32'd0, 32'h000B72DD, "if_solo");
    tie0(5, 2, "tie2");

    // Wait states on the second instance
    wait3(1'b1, 32'd7, 32'h000055AA, 32'd0, "w3_wr");
    wait3(1'b0, 32'd7, 32'd0, 32'h000055AA, "w3_rd");
    check("w3_i_ack", {31'd0, i_ack3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
